// File: rtl/s7_pkg.sv
// -----------------------------------------------------------------------------
// s7_pkg
// Shared definitions for the multiplexed 7-segment display controller.
//  - Active-low glyph patterns, bit order {a,b,c,d,e,f,g}.
//  - Handshake state encoding for the update path.
//  - s7_glyph(): nibble + mode -> segment pattern.
// -----------------------------------------------------------------------------
package s7_pkg;

   // Active-low glyphs: a '0' bit lights that segment.
   localparam logic [6:0] SEG_0    = 7'b0000001;
   localparam logic [6:0] SEG_1    = 7'b1001111;
   localparam logic [6:0] SEG_2    = 7'b0010010;
   localparam logic [6:0] SEG_3    = 7'b0000110;
   localparam logic [6:0] SEG_4    = 7'b1001100;
   localparam logic [6:0] SEG_5    = 7'b0100100;
   localparam logic [6:0] SEG_6    = 7'b0100000;
   localparam logic [6:0] SEG_7    = 7'b0001111;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0000100;
   localparam logic [6:0] SEG_A    = 7'b0001000;
   localparam logic [6:0] SEG_B    = 7'b1100000;
   localparam logic [6:0] SEG_C    = 7'b0110001;
   localparam logic [6:0] SEG_D    = 7'b1000010;
   localparam logic [6:0] SEG_E    = 7'b0110000;
   localparam logic [6:0] SEG_F    = 7'b0111000;
   localparam logic [6:0] SEG_DASH = 7'b1111110;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   // Update handshake: IDLE accepts a new request, PENDING holds it until
   // the next frame boundary.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } hs_state_t;

   // Hex mode shows 0-F; BCD mode shows a dash for any value above 9.
   function automatic logic [6:0] s7_glyph(input logic [3:0] nibble,
                                           input logic       hex_mode);
      logic [6:0] seg;
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
      if (!hex_mode && (nibble > 4'd9))
         seg = SEG_DASH;
      return seg;
   endfunction

endpackage

// File: rtl/s7_glyph_decoder.sv
// -----------------------------------------------------------------------------
// s7_glyph_decoder
// Combinational nibble -> 7-segment pattern (active-low {a..g}).
// Ports:
//  nibble    in  4  digit value
//  hex_mode  in  1  1 = hex glyphs, 0 = BCD (values >9 show a dash)
//  segments  out 7  glyph pattern
// -----------------------------------------------------------------------------
module s7_glyph_decoder
   import s7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] segments
);

   assign segments = s7_glyph(nibble, hex_mode);

endmodule

// File: rtl/s7_display_ctrl.sv
// -----------------------------------------------------------------------------
// s7_display_ctrl
// Multiplexed 7-segment driver. Scans DISPLAYS_NUM digits over one shared
// segment bus, with hex/BCD glyphs, decimal points, per-digit blink,
// leading-zero blanking and PWM brightness. Updates arrive on a valid/ready
// handshake and are only applied at a frame boundary, so a frame is never
// drawn from a mix of old and new data.
// Ports:
//  i_clk           in   clock, rising edge
//  i_rst           in   asynchronous active-low reset
//  i_data          in   4*DISPLAYS_NUM digit nibbles, digit 0 in [3:0]
//  i_dp            in   per-digit decimal point, 1 = lit
//  i_blink         in   per-digit blink enable
//  i_valid         in   update request for i_data/i_dp/i_blink
//  o_ready         out  update accepted when i_valid && o_ready
//  i_hex_mode      in   1 = hex glyphs, 0 = BCD (sampled at frame boundary)
//  i_lz_blank      in   leading-zero blanking (sampled at frame boundary)
//  i_brightness    in   lit clocks per slot (sampled at frame boundary)
//  o_segments      out  {a..g}, active-low
//  o_dp            out  decimal point, active-low
//  o_segments_sel  out  one-hot active-high digit enable
//  o_frame_start   out  pulse on the first output cycle of the digit-0 slot
// -----------------------------------------------------------------------------
module s7_display_ctrl
   import s7_pkg::*;
#(
   parameter int DISPLAYS_NUM        = 4,
   parameter int MULTIPLEX_CLK_COUNT = 10,
   parameter int BLINK_FRAMES        = 25,
   parameter int BRIGHT_W            = $clog2(MULTIPLEX_CLK_COUNT + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [4*DISPLAYS_NUM-1:0] i_data,
   input  logic [DISPLAYS_NUM-1:0]   i_dp,
   input  logic [DISPLAYS_NUM-1:0]   i_blink,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_hex_mode,
   input  logic                      i_lz_blank,
   input  logic [BRIGHT_W-1:0]       i_brightness,
   output logic [6:0]                o_segments,
   output logic                      o_dp,
   output logic [DISPLAYS_NUM-1:0]   o_segments_sel,
   output logic                      o_frame_start
);

   localparam int SLOT_W = $clog2(MULTIPLEX_CLK_COUNT);
   localparam int DIG_W  = (DISPLAYS_NUM > 1) ? $clog2(DISPLAYS_NUM) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(MULTIPLEX_CLK_COUNT - 1);
   localparam logic [DIG_W-1:0]    DIG_LAST   = DIG_W'(DISPLAYS_NUM - 1);
   localparam logic [FRM_W-1:0]    FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = BRIGHT_W'(MULTIPLEX_CLK_COUNT);

   // ---------------------------------------------------------------- scan ---
   logic [SLOT_W-1:0] slot_cnt;
   logic [DIG_W-1:0]  dig_idx;
   logic              slot_last;
   logic              fb;

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign fb        = slot_last && (dig_idx == DIG_LAST);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         slot_cnt <= '0;
         dig_idx  <= '0;
      end else if (slot_last) begin
         slot_cnt <= '0;
         dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // --------------------------------------------------------------- blink ---
   // blink_on = 1 is the visible phase; it flips every BLINK_FRAMES frames.
   logic [FRM_W-1:0] frm_cnt;
   logic             blink_on;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         frm_cnt  <= '0;
         blink_on <= 1'b1;
      end else if (fb) begin
         if (frm_cnt == FRM_LAST) begin
            frm_cnt  <= '0;
            blink_on <= ~blink_on;
         end else begin
            frm_cnt <= frm_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------- frame-sampled controls ---
   // Mode and brightness are only picked up at the boundary so a frame is
   // always drawn with one consistent setting.
   logic [BRIGHT_W-1:0] on_time;
   logic                hex_q;
   logic                lz_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         on_time <= '0;
         hex_q   <= 1'b0;
         lz_q    <= 1'b0;
      end else if (fb) begin
         on_time <= (i_brightness > BRIGHT_MAX) ? BRIGHT_MAX : i_brightness;
         hex_q   <= i_hex_mode;
         lz_q    <= i_lz_blank;
      end
   end

   // ----------------------------------------------------- handshake FSM ---
   hs_state_t state_q, state_d;
   logic      capture;
   logic      commit;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // A request captured on the boundary cycle itself is in IDLE there, so it
   // naturally waits for the following boundary before being committed.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               capture = 1'b1;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (fb) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_ready = (state_q == ST_IDLE);

   // ------------------------------------------- pending / active regs ---
   logic [DISPLAYS_NUM-1:0][3:0] pend_data, act_data;
   logic [DISPLAYS_NUM-1:0]      pend_dp, act_dp;
   logic [DISPLAYS_NUM-1:0]      pend_blink, act_blink;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blink <= '0;
      end else if (capture) begin
         pend_data  <= i_data;
         pend_dp    <= i_dp;
         pend_blink <= i_blink;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         act_data  <= '0;
         act_dp    <= '0;
         act_blink <= '0;
      end else if (commit) begin
         act_data  <= pend_data;
         act_dp    <= pend_dp;
         act_blink <= pend_blink;
      end
   end

   // ------------------------------------------------------------ glyphs ---
   logic [DISPLAYS_NUM-1:0][6:0] glyph;

   for (genvar k = 0; k < DISPLAYS_NUM; k++) begin : g_digit
      s7_glyph_decoder u_dec (
         .nibble   (act_data[k]),
         .hex_mode (hex_q),
         .segments (glyph[k])
      );
   end

   // lz_mask[k]: digit k and everything above it are zero. Digit 0 is never
   // masked so a value of zero still shows a single '0'.
   logic [DISPLAYS_NUM-1:0] lz_mask;
   logic                    zero_run;

   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int k = DISPLAYS_NUM - 1; k > 0; k--) begin
         zero_run   = zero_run && (act_data[k] == 4'h0);
         lz_mask[k] = zero_run;
      end
   end

   // ---------------------------------------------------- slot decoding ---
   logic                    lit;
   logic                    blink_blank;
   logic                    lz_blank;
   logic [DISPLAYS_NUM-1:0] nxt_sel;
   logic [6:0]              nxt_seg;
   logic                    nxt_dp;
   logic                    nxt_fs;

   // Brightness gates the whole digit (select included); blink and
   // leading-zero blanking keep the select driven and only clear the glyph.
   // Blink also hides the dp, leading-zero blanking does not.
   always_comb begin
      lit         = (BRIGHT_W'(slot_cnt) < on_time);
      blink_blank = act_blink[dig_idx] && !blink_on;
      lz_blank    = lz_q && lz_mask[dig_idx];
      nxt_sel     = '0;
      nxt_seg     = SEG_OFF;
      nxt_dp      = 1'b1;
      nxt_fs      = (slot_cnt == '0) && (dig_idx == '0);
      if (lit) begin
         nxt_sel[dig_idx] = 1'b1;
         if (!blink_blank) begin
            nxt_dp = ~act_dp[dig_idx];
            if (!lz_blank)
               nxt_seg = glyph[dig_idx];
         end
      end
   end

   // ---------------------------------------------------- output regs ---
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_segments     <= SEG_OFF;
         o_dp           <= 1'b1;
         o_segments_sel <= '0;
         o_frame_start  <= 1'b0;
      end else begin
         o_segments     <= nxt_seg;
         o_dp           <= nxt_dp;
         o_segments_sel <= nxt_sel;
         o_frame_start  <= nxt_fs;
      end
   end

endmodule

// File: tb/tb_s7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s7_display_ctrl
// Stimulus issues updates aligned to frame starts and pushes the expected
// picture of a given frame number into a scoreboard queue. The monitor
// records every output frame (40 cycles) and, when that frame completes,
// compares it against the queued entry carrying the same frame number.
// Frame numbers count o_frame_start pulses since the last reset (first = 0).
// -----------------------------------------------------------------------------
module tb_s7_display_ctrl;

   localparam int DN  = 4;
   localparam int MCC = 10;
   localparam int BF  = 2;
   localparam int BW  = 4;
   localparam int FRAME_CYC = DN * MCC;

   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   i_data = '0;
   logic [3:0]    i_dp = '0;
   logic [3:0]    i_blink = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic          i_hex_mode = 1'b0;
   logic          i_lz_blank = 1'b0;
   logic [BW-1:0] i_brightness = 4'd10;
   logic [6:0]    o_segments;
   logic          o_dp;
   logic [3:0]    o_segments_sel;
   logic          o_frame_start;

   always #5 clk = ~clk;

   s7_display_ctrl #(
      .DISPLAYS_NUM        (DN),
      .MULTIPLEX_CLK_COUNT (MCC),
      .BLINK_FRAMES        (BF),
      .BRIGHT_W            (BW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_data         (i_data),
      .i_dp           (i_dp),
      .i_blink        (i_blink),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_hex_mode     (i_hex_mode),
      .i_lz_blank     (i_lz_blank),
      .i_brightness   (i_brightness),
      .o_segments     (o_segments),
      .o_dp           (o_dp),
      .o_segments_sel (o_segments_sel),
      .o_frame_start  (o_frame_start)
   );

   typedef struct {
      int          frame;
      logic [3:0][6:0] seg;
      logic [3:0]  dp;
      int          on;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // ------------------------------------------------------ expected model ---
   function automatic exp_t mk(int frame, logic [15:0] data, logic [3:0] dp,
                               logic [3:0] blink, logic hex, logic lz,
                               int bright, string name);
      exp_t e;
      logic [3:0] nib;
      e.frame = frame;
      e.on    = (bright > MCC) ? MCC : bright;
      e.name  = name;
      for (int k = 0; k < 4; k++) begin
         nib      = data[4*k +: 4];
         e.seg[k] = (!hex && nib > 4'd9) ? 7'b1111110 : GLYPH[nib];
         e.dp[k]  = ~dp[k];
         if (lz && k > 0 && (data >> (4*k)) == 16'h0)
            e.seg[k] = 7'h7F;
         if (blink[k] && ((frame / BF) % 2 == 1)) begin
            e.seg[k] = 7'h7F;
            e.dp[k]  = 1'b1;
         end
      end
      return e;
   endfunction

   // ------------------------------------------------------------ monitor ---
   int         frame_no  = -1;
   int         buf_frame = -1;
   int         buf_cnt   = 0;
   logic [3:0] sel_b [FRAME_CYC];
   logic [6:0] seg_b [FRAME_CYC];
   logic       dp_b  [FRAME_CYC];

   task automatic check_frame(int fr);
      exp_t       e;
      int         bad;
      logic [3:0] es, bs;
      logic [6:0] eg, bg;
      logic       ed, bd;
      while (sb.size() > 0 && sb[0].frame < fr) begin
         e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: frame %0d never observed (monitor at frame %0d)",
                  e.name, e.frame, fr);
      end
      if (sb.size() == 0 || sb[0].frame != fr) return;
      e   = sb.pop_front();
      tests++;
      bad = -1;
      es = '0; eg = '0; ed = 1'b0; bs = '0; bg = '0; bd = 1'b0;
      for (int k = 0; k < DN; k++) begin
         for (int c = 0; c < MCC; c++) begin
            int         idx;
            logic [3:0] xs;
            logic [6:0] xg;
            logic       xd;
            idx = k * MCC + c;
            xs  = (c < e.on) ? 4'(1 << k) : 4'b0000;
            xg  = (c < e.on) ? e.seg[k] : 7'h7F;
            xd  = (c < e.on) ? e.dp[k] : 1'b1;
            if (bad < 0 && (sel_b[idx] !== xs || seg_b[idx] !== xg || dp_b[idx] !== xd)) begin
               bad = idx;
               es = xs; eg = xg; ed = xd;
               bs = sel_b[idx]; bg = seg_b[idx]; bd = dp_b[idx];
            end
         end
      end
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s frame %0d cycle %0d: got sel=%b seg=%b dp=%b, want sel=%b seg=%b dp=%b",
                  e.name, fr, bad, bs, bg, bd, es, eg, ed);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         frame_no = -1;
         buf_cnt  = 0;
      end else begin
         if (o_frame_start) begin
            if (buf_cnt == FRAME_CYC) check_frame(buf_frame);
            frame_no++;
            buf_frame = frame_no;
            buf_cnt   = 0;
         end
         if (frame_no >= 0 && buf_frame == frame_no && buf_cnt < FRAME_CYC) begin
            sel_b[buf_cnt] = o_segments_sel;
            seg_b[buf_cnt] = o_segments;
            dp_b[buf_cnt]  = o_dp;
            buf_cnt++;
         end
      end
   end

   // ------------------------------------------------------ stimulus utils ---
   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Returns #1 after the negedge on which the next o_frame_start is seen.
   task automatic wait_frame(output int f);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_frame_start && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      f = frame_no;
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL wait_frame: no o_frame_start within 200 cycles");
      end
   endtask

   task automatic goto_frame(int target);
      int f;
      int n;
      f = -100;
      n = 0;
      while (f < target && n < 10) begin
         wait_frame(f);
         n++;
      end
      if (f != target) begin
         tests++;
         fails++;
         $display("FAIL goto_frame: reached frame %0d want %0d", f, target);
      end
   endtask

   // One-cycle valid pulse; returns on the following negedge.
   task automatic send(logic [15:0] d, logic [3:0] dp, logic [3:0] bl);
      i_data  = d;
      i_dp    = dp;
      i_blink = bl;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus ---
   initial begin
      int f;
      int rdy_hi;

      // Reset values while held in reset
      repeat (3) @(negedge clk);
      check("rst_segments", 32'(o_segments), 32'h7F);
      check("rst_dp", 32'(o_dp), 32'd1);
      check("rst_sel", 32'(o_segments_sel), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_frame_start", 32'(o_frame_start), 32'd0);
      rst_n = 1'b1;

      // 1: basic BCD scan, full brightness
      wait_frame(f);                       // frame 0 (dark: on_time reset 0)
      send(16'h1234, 4'b0000, 4'b0000);
      check("t1_ready_low", 32'(o_ready), 32'd0);
      sb.push_back(mk(f+1, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t1_scan_a"));
      sb.push_back(mk(f+2, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t1_scan_b"));
      goto_frame(f+2);

      // 2: valid while PENDING is ignored; capture on the FB cycle lags a frame
      f = frame_no;
      send(16'h4321, 4'b0000, 4'b0000);
      i_data  = 16'h5678;
      i_valid = 1'b1;
      rdy_hi  = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_ready) rdy_hi++;
         @(negedge clk);
      end
      i_valid = 1'b0;
      check("t2_ready_low_pending", 32'(rdy_hi), 32'd0);
      sb.push_back(mk(f+1, 16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t2_pending_ignored"));
      goto_frame(f+1);
      repeat (38) @(negedge clk);          // output cycle 38 = FB cycle
      check("t2_ready_at_fb", 32'(o_ready), 32'd1);
      send(16'h8765, 4'b0000, 4'b0000);
      check("t2_ready_after_fb_capture", 32'(o_ready), 32'd0);
      sb.push_back(mk(f+2, 16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t2_fb_capture_held"));
      sb.push_back(mk(f+3, 16'h8765, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t2_fb_capture_shown"));
      goto_frame(f+3);

      // 3: hex / BCD glyphs and leading-zero blanking
      f = frame_no;
      i_hex_mode = 1'b1;
      send(16'h00A7, 4'b0000, 4'b0000);
      sb.push_back(mk(f+1, 16'h00A7, 4'b0000, 4'b0000, 1'b1, 1'b0, 10, "t3_hex"));
      goto_frame(f+1);
      i_hex_mode = 1'b0;
      sb.push_back(mk(f+2, 16'h00A7, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, "t3_bcd_dash"));
      goto_frame(f+2);
      i_lz_blank = 1'b1;
      send(16'h0007, 4'b0000, 4'b0000);
      sb.push_back(mk(f+3, 16'h0007, 4'b0000, 4'b0000, 1'b0, 1'b1, 10, "t3_lz_blank"));
      goto_frame(f+3);

      // 4: brightness
      f = frame_no;
      i_lz_blank   = 1'b0;
      i_brightness = 4'd3;
      send(16'h1234, 4'b0000, 4'b0000);
      sb.push_back(mk(f+1, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, "t4_bright3"));
      goto_frame(f+1);
      repeat (15) @(negedge clk);
      i_brightness = 4'd0;                 // mid-frame: frame f+1 keeps 3
      sb.push_back(mk(f+2, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, "t4_bright0"));
      goto_frame(f+2);
      i_brightness = 4'd15;
      sb.push_back(mk(f+3, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 15, "t4_bright_clamp"));
      goto_frame(f+3);

      // 5: blink on digit 1, decimal point on digit 2
      f = frame_no;
      send(16'h1234, 4'b0100, 4'b0010);
      for (int k = 1; k <= 4; k++)
         sb.push_back(mk(f+k, 16'h1234, 4'b0100, 4'b0010, 1'b0, 1'b0, 15, "t5_blink_dp"));
      goto_frame(f+4);
      drain();

      // 6: async reset mid-slot with an update pending
      wait_frame(f);
      send(16'h9999, 4'b1111, 4'b0000);
      check("t6_pending_before_rst", 32'(o_ready), 32'd0);
      repeat (4) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_segments", 32'(o_segments), 32'h7F);
      check("t6_rst_dp", 32'(o_dp), 32'd1);
      check("t6_rst_sel", 32'(o_segments_sel), 32'd0);
      check("t6_rst_ready", 32'(o_ready), 32'd1);
      check("t6_rst_frame_start", 32'(o_frame_start), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t6_ready_after_release", 32'(o_ready), 32'd1);
      sb.push_back(mk(0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, "t6_frame0_dark"));
      sb.push_back(mk(1, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 15, "t6_zeros"));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
